// File: rtl/control_pkg.sv
// Shared control-block constants, AXI-lite widths and the dispatcher state encoding.
// Imported by the dispatcher, its AXI-lite interface and the control slave.
package control_pkg;

   localparam int AXI_ADDR_WIDTH             = 32;
   localparam int AXI_DATA_WIDTH             = 32;
   localparam int AXI_STRB_WIDTH             = AXI_DATA_WIDTH / 8;
   localparam int NUM_NODES_PROCESSING       = 8;
   localparam int NUM_NODES_PROCESSING_WIDTH =
      (NUM_NODES_PROCESSING > 1) ? $clog2(NUM_NODES_PROCESSING) : 1;

   // A register index is the address bit that selects it inside the control block.
   localparam int REG_PROG         = 7;
   localparam int REG_BUSY         = 8;
   localparam int REG_COUNT        = 9;
   localparam int REG_COUNT_GLOBAL = 10;
   localparam int REG_LEDS_STATUS  = 18;
   localparam int REG_TRIGGERS     = 19;
   localparam int NODE_LSB         = 2;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POLL_AR,
      ST_POLL_R,
      ST_SELECT,
      ST_WAIT,
      ST_WRITE_REQ,
      ST_WRITE_B
   } disp_state_e;

   function automatic logic [AXI_ADDR_WIDTH-1:0] reg_addr(
      input logic [AXI_ADDR_WIDTH-1:0] base,
      input int                        idx
   );
      return base | (AXI_ADDR_WIDTH'(1) << idx);
   endfunction

   function automatic logic [AXI_ADDR_WIDTH-1:0] prog_addr(
      input logic [AXI_ADDR_WIDTH-1:0]             base,
      input logic [NUM_NODES_PROCESSING_WIDTH-1:0] node
   );
      return reg_addr(base, REG_PROG) | (AXI_ADDR_WIDTH'(node) << NODE_LSB);
   endfunction

endpackage

// File: rtl/if_axi_light.sv
// AXI-lite bundle between interconnect masters and the control slave.
interface if_axi_light;
   import control_pkg::*;

   logic [AXI_ADDR_WIDTH-1:0] awaddr;
   logic [2:0]                awprot;
   logic                      awvalid;
   logic                      awready;
   logic [AXI_DATA_WIDTH-1:0] wdata;
   logic [AXI_STRB_WIDTH-1:0] wstrb;
   logic                      wvalid;
   logic                      wready;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic [2:0]                arprot;
   logic                      arvalid;
   logic                      arready;
   logic [AXI_DATA_WIDTH-1:0] rdata;
   logic [1:0]                rresp;
   logic                      rvalid;
   logic                      rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/control_dispatcher_prio_enc_free.sv
// Lowest-zero priority encoder: index of the first idle node in a busy vector.
module prio_enc_free #(
   parameter int NUM_NODES = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_NODES-1:0] busy,
   output logic                 found,
   output logic [IDX_W-1:0]     index
);

   // Scan from the top down so the lowest idle index is the last one written.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int n = NUM_NODES - 1; n >= 0; n--) begin
         if (!busy[n]) begin
            found = 1'b1;
            index = IDX_W'(n);
         end
      end
   end

endmodule

// File: rtl/control_dispatcher.sv
// AXI-lite master that polls the control busy register and writes each task's
// program offset into the lowest-index idle node's program register.
module control_dispatcher
   import control_pkg::*;
#(
   parameter logic [AXI_ADDR_WIDTH-1:0] CTRL_BASE = 32'h0000_0000,
   parameter int                        NUM_NODES = NUM_NODES_PROCESSING,
   parameter int                        POLL_GAP  = 16
) (
   input  logic                                  clk,
   input  logic                                  res,
   if_axi_light.master                           m_axi,
   input  logic                                  task_valid,
   output logic                                  task_ready,
   input  logic [AXI_DATA_WIDTH-1:0]             task_offset,
   output logic                                  disp_valid,
   output logic [NUM_NODES_PROCESSING_WIDTH-1:0] disp_node,
   output logic                                  err_resp,
   output logic                                  err_zero,
   output logic [31:0]                           disp_total,
   output logic                                  busy_o
);

   localparam int NODE_W = NUM_NODES_PROCESSING_WIDTH;

   disp_state_e               state;
   disp_state_e               state_nx;
   logic [AXI_DATA_WIDTH-1:0] offset_q;
   logic [NUM_NODES-1:0]      busy_q;
   logic [NODE_W-1:0]         node_q;
   logic [15:0]               wait_cnt;
   logic                      aw_done;
   logic                      w_done;
   logic                      free_found;
   logic [NODE_W-1:0]         free_idx;

   logic arvalid;
   logic rready;
   logic awvalid;
   logic wvalid;
   logic bready;
   logic aw_hs;
   logic w_hs;

   prio_enc_free #(
      .NUM_NODES (NUM_NODES),
      .IDX_W     (NODE_W)
   ) u_prio_enc_free (
      .busy  (busy_q),
      .found (free_found),
      .index (free_idx)
   );

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (res) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx   = state;
      task_ready = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      disp_valid = 1'b0;
      err_resp   = 1'b0;
      err_zero   = 1'b0;
      if (!res) begin
         unique case (state)
            ST_IDLE: begin
               task_ready = 1'b1;
               if (task_valid) begin
                  if (task_offset == '0) err_zero = 1'b1;
                  else                   state_nx = ST_POLL_AR;
               end
            end
            ST_POLL_AR: begin
               arvalid = 1'b1;
               if (m_axi.arready) state_nx = ST_POLL_R;
            end
            ST_POLL_R: begin
               rready = 1'b1;
               if (m_axi.rvalid) begin
                  if (m_axi.rresp != RESP_OKAY) begin
                     err_resp = 1'b1;
                     state_nx = ST_WAIT;
                  end else begin
                     state_nx = ST_SELECT;
                  end
               end
            end
            ST_SELECT: state_nx = free_found ? ST_WRITE_REQ : ST_WAIT;
            ST_WAIT: begin
               if (wait_cnt == 16'd0) state_nx = ST_POLL_AR;
            end
            ST_WRITE_REQ: begin
               awvalid = !aw_done;
               wvalid  = !w_done;
               aw_hs   = awvalid && m_axi.awready;
               w_hs    = wvalid && m_axi.wready;
               if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = ST_WRITE_B;
            end
            ST_WRITE_B: begin
               bready = 1'b1;
               if (m_axi.bvalid) begin
                  if (m_axi.bresp == RESP_OKAY) begin
                     disp_valid = 1'b1;
                     state_nx   = ST_IDLE;
                  end else begin
                     err_resp = 1'b1;
                     state_nx = ST_WAIT;
                  end
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         offset_q   <= '0;
         busy_q     <= '0;
         node_q     <= '0;
         wait_cnt   <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         disp_total <= '0;
      end else begin
         if (task_ready && task_valid) offset_q <= task_offset;
         if (rready && m_axi.rvalid)   busy_q   <= m_axi.rdata[NUM_NODES-1:0];
         if (state == ST_SELECT) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (free_found) node_q <= free_idx;
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
         end
         // The gap counter reloads on every entry, whichever state it came from.
         if (state_nx == ST_WAIT && state != ST_WAIT)
            wait_cnt <= 16'(POLL_GAP - 1);
         else if (state == ST_WAIT && wait_cnt != 16'd0)
            wait_cnt <= wait_cnt - 16'd1;
         if (disp_valid) disp_total <= disp_total + 32'd1;
      end
   end

   // Address and data only change in SELECT/IDLE, so they are stable while valid is high.
   assign m_axi.araddr  = reg_addr(CTRL_BASE, REG_BUSY);
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = arvalid;
   assign m_axi.rready  = rready;
   assign m_axi.awaddr  = prog_addr(CTRL_BASE, node_q);
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = awvalid;
   assign m_axi.wdata   = offset_q;
   assign m_axi.wstrb   = '1;
   assign m_axi.wvalid  = wvalid;
   assign m_axi.bready  = bready;

   assign disp_node = node_q;
   assign busy_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_control_dispatcher.sv
// Directed bench for control_dispatcher: reactive AXI-lite slave, a transaction-level
// model checked every cycle, and literal expectations per scenario.
module tb_control_dispatcher;
   import control_pkg::*;

   localparam logic [31:0] BASE  = 32'h4000_0000;
   localparam int          NN    = 4;
   localparam int          GAP   = 5;
   localparam int          NW    = NUM_NODES_PROCESSING_WIDTH;

   logic          clk = 1'b0;
   logic          res;
   logic          task_valid;
   logic          task_ready;
   logic [31:0]   task_offset;
   logic          disp_valid;
   logic [NW-1:0] disp_node;
   logic          err_resp;
   logic          err_zero;
   logic [31:0]   disp_total;
   logic          busy_o;

   if_axi_light axi ();

   control_dispatcher #(
      .CTRL_BASE (BASE),
      .NUM_NODES (NN),
      .POLL_GAP  (GAP)
   ) dut (
      .clk         (clk),
      .res         (res),
      .m_axi       (axi),
      .task_valid  (task_valid),
      .task_ready  (task_ready),
      .task_offset (task_offset),
      .disp_valid  (disp_valid),
      .disp_node   (disp_node),
      .err_resp    (err_resp),
      .err_zero    (err_zero),
      .disp_total  (disp_total),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- slave configuration and response queues ----------------
   logic [33:0] rd_q[$];   // {rresp, rdata}
   logic [1:0]  b_q[$];
   int aw_dly = 0, w_dly = 0, b_dly = 0;
   int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   bit aw_got = 0, w_got = 0;

   task automatic cfg(input int aw, input int w, input int b);
      aw_dly = aw; w_dly = w; b_dly = b;
      aw_cnt = aw; w_cnt = w; b_cnt = b;
   endtask

   // Slave reacts on the falling edge; the DUT samples its outputs at the next rising edge.
   initial begin
      forever begin
         @(negedge clk);
         if (res) begin
            axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00;
            axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
            aw_got = 0; w_got = 0;
            aw_cnt = aw_dly; w_cnt = w_dly; b_cnt = b_dly;
         end else begin
            if (axi.rvalid) axi.rvalid = 0;
            if (axi.arready) begin
               axi.arready = 0;
               axi.rvalid  = 1;
               if (rd_q.size() > 0) {axi.rresp, axi.rdata} = rd_q.pop_front();
               else                 {axi.rresp, axi.rdata} = 34'h0;
            end else if (axi.arvalid) begin
               axi.arready = 1;
            end
            if (axi.awready) begin
               axi.awready = 0; aw_got = 1;
            end else if (axi.awvalid && !aw_got) begin
               if (aw_cnt == 0) axi.awready = 1; else aw_cnt--;
            end
            if (axi.wready) begin
               axi.wready = 0; w_got = 1;
            end else if (axi.wvalid && !w_got) begin
               if (w_cnt == 0) axi.wready = 1; else w_cnt--;
            end
            if (axi.bvalid) begin
               axi.bvalid = 0;
            end else if (aw_got && w_got) begin
               if (b_cnt == 0) begin
                  axi.bvalid = 1;
                  axi.bresp  = (b_q.size() > 0) ? b_q.pop_front() : 2'b00;
                  aw_got = 0; w_got = 0;
                  aw_cnt = aw_dly; w_cnt = w_dly; b_cnt = b_dly;
               end else begin
                  b_cnt--;
               end
            end
         end
      end
   end

   // ---------------- transaction-level model and per-cycle compare ----------------
   bit          m_in_flight = 0;
   logic [31:0] m_total     = 0;
   logic [31:0] m_offset    = 0;
   int          m_node      = -1;
   int          cyc = 0, n_ar = 0, n_err = 0, n_disp = 0, n_zero = 0;
   int          rises[$];
   logic [31:0] last_araddr, last_awaddr, last_wdata;
   int          last_node;
   bit          p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
   logic [31:0] p_araddr, p_awaddr, p_wdata;

   initial begin
      bit hs, bad, ok_b;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (res) begin
            check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 0);
            check("rst_pulses", {task_ready, disp_valid, err_resp, err_zero}, 0);
            m_in_flight = 0; m_total = 0; m_node = -1;
            p_arv = 0; p_awv = 0; p_wv = 0;
         end else begin
            check("task_ready", task_ready, !m_in_flight);
            check("busy_o", busy_o, m_in_flight);
            check("disp_total", disp_total, m_total);
            if (!m_in_flight) check("idle_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 0);
            bad  = (axi.rvalid && axi.rresp != 2'b00) || (axi.bvalid && axi.bresp != 2'b00);
            ok_b = axi.bvalid && axi.bresp == 2'b00;
            hs   = task_valid && !m_in_flight;
            check("err_resp", err_resp, bad);
            check("disp_valid", disp_valid, ok_b);
            check("err_zero", err_zero, hs && task_offset == 32'h0);
            if (p_arv && !p_arr) check("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
            if (p_awv && !p_awr) check("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)   check("w_hold", {axi.wvalid, axi.wdata}, {1'b1, p_wdata});
            if (axi.arvalid && !p_arv) rises.push_back(cyc);
            if (axi.arvalid && axi.arready) begin
               check("ar_addr", {axi.arprot, axi.araddr}, {3'b000, BASE + 32'h100});
               n_ar++;
               last_araddr = axi.araddr;
            end
            if (axi.rvalid) begin
               m_node = -1;
               if (axi.rresp == 2'b00)
                  for (int n = 0; n < NN; n++)
                     if (m_node < 0 && axi.rdata[n] == 1'b0) m_node = n;
            end
            if (axi.awvalid && axi.awready) begin
               check("aw_addr", {axi.awprot, axi.awaddr},
                     (m_node < 0) ? 64'hBAD : {3'b000, BASE + 32'h80 + 32'(4 * m_node)});
               last_awaddr = axi.awaddr;
            end
            if (axi.wvalid && axi.wready) begin
               check("w_data", {axi.wstrb, axi.wdata}, {4'hF, m_offset});
               last_wdata = axi.wdata;
            end
            if (ok_b) begin
               check("disp_node", disp_node, m_node);
               last_node = int'(disp_node);
               m_total++;
               m_in_flight = 0;
               n_disp++;
            end
            if (bad) n_err++;
            if (err_zero) n_zero++;
            if (hs && task_offset != 32'h0) begin
               m_in_flight = 1;
               m_offset    = task_offset;
            end
            p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
            p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
            p_wv  = axi.wvalid;  p_wr  = axi.wready;  p_wdata  = axi.wdata;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_task(input logic [31:0] off);
      int n;
      @(negedge clk);
      task_valid  = 1;
      task_offset = off;
      #1;
      n = 0;
      while (!task_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) check("send_timeout", 1, 0);
      @(posedge clk);
   endtask

   // Latency counts falling edges after the accepting edge up to the disp_valid cycle.
   task automatic run_task(input logic [31:0] off, output int lat);
      send_task(off);
      lat = 0;
      do begin
         @(negedge clk);
         task_valid = 0;
         #3;
         lat++;
      end while (!disp_valid && lat < 300);
      if (!disp_valid) check("disp_timeout", 1, 0);
      @(negedge clk);
      #3;
   endtask

   initial begin
      int lat, ar0, er0, dp0, zr0, n;
      logic [31:0] tot0;
      res = 1; task_valid = 0; task_offset = '0;
      cfg(0, 0, 0);
      repeat (3) @(negedge clk);
      #3;
      check("rst_task_ready", task_ready, 0);
      check("rst_disp_total", disp_total, 0);
      check("rst_disp_node", disp_node, 0);
      check("rst_busy_o", busy_o, 0);
      @(negedge clk);
      res = 0;
      #3;
      check("first_task_ready", task_ready, 1);

      // single dispatch, everything idle
      rd_q.push_back({2'b00, 32'h0});
      run_task(32'h0001_0000, lat);
      check("t1_latency", lat, 5);
      check("t1_araddr", last_araddr, 32'h4000_0100);
      check("t1_awaddr", last_awaddr, 32'h4000_0080);
      check("t1_wdata", last_wdata, 32'h0001_0000);
      check("t1_node", last_node, 0);
      check("t1_total", disp_total, 1);

      // nodes 0..2 busy
      rd_q.push_back({2'b00, 32'h0000_0007});
      run_task(32'h0000_2000, lat);
      check("t2_awaddr", last_awaddr, 32'h4000_008C);
      check("t2_node", last_node, 3);
      check("t2_total", disp_total, 2);

      // all busy twice, then node 1 free; rise-to-rise = POLL_AR + POLL_R + SELECT + GAP
      rises.delete();
      ar0 = n_ar;
      rd_q.push_back({2'b00, 32'h0000_000F});
      rd_q.push_back({2'b00, 32'h0000_000F});
      rd_q.push_back({2'b00, 32'h0000_000D});
      run_task(32'h0000_3300, lat);
      check("t3_polls", n_ar - ar0, 3);
      n = rises.size();
      check("t3_rises", n, 3);
      if (n == 3) begin
         check("t3_gap0", rises[1] - rises[0], 8);
         check("t3_gap1", rises[2] - rises[1], 8);
      end
      check("t3_awaddr", last_awaddr, 32'h4000_0084);
      check("t3_node", last_node, 1);

      // busy bits above NUM_NODES are ignored in both directions
      rd_q.push_back({2'b00, 32'hFFFF_FFEF});
      rd_q.push_back({2'b00, 32'hFFFF_FFFB});
      run_task(32'h0000_4400, lat);
      check("t4_awaddr", last_awaddr, 32'h4000_0088);
      check("t4_node", last_node, 2);
      check("t4_total", disp_total, 4);

      // zero offset is dropped
      zr0 = n_zero; ar0 = n_ar;
      send_task(32'h0);
      @(negedge clk);
      task_valid = 0;
      #3;
      check("t5_ready_back", task_ready, 1);
      check("t5_err_zero", n_zero - zr0, 1);
      repeat (6) @(negedge clk);
      #3;
      check("t5_no_axi", n_ar - ar0, 0);
      check("t5_total", disp_total, 4);

      // AWREADY 3 cycles before WREADY, first BRESP is SLVERR
      cfg(0, 3, 0);
      ar0 = n_ar; er0 = n_err; dp0 = n_disp; tot0 = disp_total;
      rd_q.push_back({2'b00, 32'h0});
      rd_q.push_back({2'b00, 32'h0});
      b_q.push_back(2'b10);
      b_q.push_back(2'b00);
      run_task(32'h0000_5500, lat);
      check("t6_err", n_err - er0, 1);
      check("t6_repoll", n_ar - ar0, 2);
      check("t6_disp", n_disp - dp0, 1);
      check("t6_total", disp_total, tot0 + 32'd1);
      check("t6_wdata", last_wdata, 32'h0000_5500);
      cfg(0, 0, 0);

      // read error: re-poll after POLL_AR + POLL_R + GAP
      rises.delete();
      er0 = n_err;
      rd_q.push_back({2'b10, 32'h0});
      rd_q.push_back({2'b00, 32'h0000_000E});
      run_task(32'h0000_6600, lat);
      check("t7_err", n_err - er0, 1);
      check("t7_gap", (rises.size() == 2) ? rises[1] - rises[0] : -1, 7);
      check("t7_node", last_node, 0);

      // reset while waiting for BRESP
      cfg(0, 0, 4);
      rd_q.push_back({2'b00, 32'h0000_0003});
      send_task(32'h0000_7700);
      n = 0;
      do begin
         @(negedge clk);
         task_valid = 0;
         #3;
         n++;
      end while (!axi.bready && n < 50);
      check("t8_reached_write_b", axi.bready, 1);
      res = 1;
      @(negedge clk);
      #3;
      check("t8_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready}, 0);
      check("t8_total", disp_total, 0);
      @(negedge clk);
      res = 0;
      cfg(0, 0, 0);
      #3;
      check("t8_idle", {busy_o, task_ready}, 2'b01);

      // recovery after reset
      rd_q.delete(); b_q.delete();
      rd_q.push_back({2'b00, 32'h0000_0001});
      run_task(32'h0000_8800, lat);
      check("t9_node", last_node, 1);
      check("t9_total", disp_total, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
